mem_port_arbiter: RTL and testbench

- Shares the single-port `memory` block between two requesters: instruction fetch (IF) and load/store data (D).
- Sits between the core front end / LSU and `memory`, and drives its addr/write_data/mem_read/mem_write/byte_enable inputs.
- Default priority goes to D. A starvation counter guarantees IF forward progress.
- Responses are tagged back to the originating port. Out-of-range and timed-out accesses return an error instead of hanging the core.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_arb_prio.sv | 37 +++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, owner tags and the
// full-word byte-enable constant.
package mem_pkg;

    localparam int MEM_BYTES_DEF = 1024;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_BUSY = 1'b1
    } state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed data-port priority with a saturating starvation counter that hands the
// memory to instruction fetch after STARVE_LIMIT refused cycles.
module mem_arb_prio #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic if_req,
    input  logic d_req,
    output logic if_win,
    output logic d_win
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          if_first;

    always_comb begin
        if_first = if_req && (starve_cnt == CW'(STARVE_LIMIT));
        d_win    = en && d_req && !if_first;
        if_win   = en && if_req && !d_win;
    end

    // Counts refused IF cycles, including the cycles spent waiting out BUSY
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (if_win) begin
            starve_cnt <= '0;
        end else if (if_req && (starve_cnt != CW'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// returning tagged responses with an error for out-of-range or timed-out accesses.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_BYTES    = MEM_BYTES_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state, state_nxt;
    logic              owner;
    logic [TW-1:0]     tcnt;
    logic              arb_en, if_win, d_win, grant;
    logic              sel_owner, sel_we, sel_in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic              done_ok, done_to;

    logic              vld_p1;
    logic              own_p1;
    logic              err_p1;
    logic [DATA_W-1:0] data_p1;

    mem_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (arb_en),
        .if_req (if_req),
        .d_req  (d_req),
        .if_win (if_win),
        .d_win  (d_win)
    );

    always_comb begin
        arb_en       = reset_n && (state == STATE_IDLE);
        grant        = if_win || d_win;
        sel_owner    = d_win ? OWNER_D : OWNER_IF;
        sel_we       = d_win && d_we;
        sel_addr     = d_win ? d_addr : if_addr;
        sel_in_range = sel_addr < ADDR_W'(MEM_BYTES);
        done_ok      = (state == STATE_BUSY) && mem_ready;
        done_to      = (state == STATE_BUSY) && !mem_ready && (tcnt == TW'(TIMEOUT - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            STATE_IDLE: if (grant && sel_in_range) state_nxt = STATE_BUSY;
            STATE_BUSY: if (done_ok || done_to)    state_nxt = STATE_IDLE;
            default:                               state_nxt = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= STATE_IDLE;
        else          state <= state_nxt;
    end

    // Request latch / memory drive, then the registered response stage (_p1)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner     <= OWNER_IF;
            tcnt      <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            vld_p1    <= 1'b0;
            own_p1    <= OWNER_IF;
            err_p1    <= 1'b0;
            data_p1   <= '0;
        end else begin
            vld_p1 <= 1'b0;
            if (grant) begin
                owner <= sel_owner;
                if (sel_in_range) begin
                    mem_addr  <= sel_addr & ~ADDR_W'(3);
                    mem_wdata <= sel_we ? d_wdata : '0;
                    mem_be    <= sel_we ? d_be : BE_WORD;
                    mem_read  <= !sel_we;
                    mem_write <= sel_we;
                    tcnt      <= '0;
                end else begin
                    vld_p1  <= 1'b1;
                    own_p1  <= sel_owner;
                    err_p1  <= 1'b1;
                    data_p1 <= '0;
                end
            end else if (done_ok || done_to) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                vld_p1    <= 1'b1;
                own_p1    <= owner;
                err_p1    <= done_to;
                data_p1   <= (done_ok && mem_read) ? mem_rdata : '0;
            end else if (state == STATE_BUSY) begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

    always_comb begin
        if_gnt    = if_win;
        d_gnt     = d_win;
        if_rvalid = vld_p1 && (own_p1 == OWNER_IF);
        d_rvalid  = vld_p1 && (own_p1 == OWNER_D);
        if_rdata  = if_rvalid ? data_p1 : '0;
        d_rdata   = d_rvalid ? data_p1 : '0;
        if_err    = if_rvalid && err_p1;
        d_err     = d_rvalid && err_p1;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural word memory
// whose ready can be held low to force timeouts.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_ready;
    logic [3:0]  mem_be;

    logic        stall;
    logic        mem_clr;
    logic [31:0] mem_arr [0:255];
    logic [139:0] all_outs;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_be   (mem_be),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ready = (mem_read || mem_write) && !stall;
    assign mem_rdata = (mem_addr < 32'd1024) ? mem_arr[mem_addr[9:2]] : 32'h0;
    assign all_outs  = {if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, mem_read, mem_write,
                        mem_be, mem_addr, mem_wdata, if_rdata, d_rdata};

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h0;
        end else if (mem_write && mem_ready) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        mem_clr = 1'b0;
        checks++;
        if (all_outs !== 140'h0) begin
            errors++;
            $display("FAIL reset_outs got %h exp 0", all_outs);
        end
        if_req = 1'b1; d_req = 1'b1;
        #1;
        checks++;
        if ({if_gnt, d_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL reset_gnt got %b exp 00", {if_gnt, d_gnt});
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_if_read();
        // preload 0x40 with a full-word D write
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hABCDEF00; d_be = 4'b1111;
        #1;
        checks++;
        if (d_gnt !== 1'b1) begin errors++; $display("FAIL preload_gnt got %b exp 1", d_gnt); end
        @(negedge clk);
        d_req = 1'b0;
        checks++;
        if ({mem_write, mem_addr, mem_be} !== {1'b1, 32'h40, 4'hF}) begin
            errors++;
            $display("FAIL preload_mem got %b %h %h exp 1 00000040 f", mem_write, mem_addr, mem_be);
        end
        @(negedge clk);
        checks++;
        if ({d_rvalid, d_err, d_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL preload_rsp got %b %b %h exp 1 0 0", d_rvalid, d_err, d_rdata);
        end
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h41;
        #1;
        checks++;
        if ({if_gnt, d_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL if_gnt got %b exp 10", {if_gnt, d_gnt});
        end
        @(negedge clk);
        if_req = 1'b0;
        checks++;
        if ({mem_read, mem_write, mem_addr, mem_be} !== {1'b1, 1'b0, 32'h40, 4'hF}) begin
            errors++;
            $display("FAIL if_mem got %b %b %h %h exp 1 0 00000040 f", mem_read, mem_write, mem_addr, mem_be);
        end
        @(negedge clk);
        checks++;
        if ({if_rvalid, if_err, if_rdata, d_rvalid} !== {1'b1, 1'b0, 32'hABCDEF00, 1'b0}) begin
            errors++;
            $display("FAIL if_rsp got %b %b %h %b exp 1 0 abcdef00 0", if_rvalid, if_err, if_rdata, d_rvalid);
        end
        @(negedge clk);
        checks++;
        if ({if_rvalid, mem_read} !== 2'b00) begin
            errors++;
            $display("FAIL if_pulse got %b exp 00", {if_rvalid, mem_read});
        end
    endtask

    task automatic test_d_byte_write();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h08; d_wdata = 32'hAABBCCDD; d_be = 4'b0010;
        #1;
        checks++;
        if (d_gnt !== 1'b1) begin errors++; $display("FAIL bw_gnt got %b exp 1", d_gnt); end
        @(negedge clk);
        d_req = 1'b0;
        checks++;
        if ({mem_write, mem_be, mem_wdata, mem_addr} !== {1'b1, 4'b0010, 32'hAABBCCDD, 32'h08}) begin
            errors++;
            $display("FAIL bw_mem got %b %b %h %h exp 1 0010 aabbccdd 00000008", mem_write, mem_be, mem_wdata, mem_addr);
        end
        @(negedge clk);
        checks++;
        if ({d_rvalid, d_err, d_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL bw_rsp got %b %b %h exp 1 0 0", d_rvalid, d_err, d_rdata);
        end
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h08;
        #1;
        checks++;
        if (d_gnt !== 1'b1) begin errors++; $display("FAIL br_gnt got %b exp 1", d_gnt); end
        @(negedge clk);
        d_req = 1'b0;
        checks++;
        if ({mem_read, mem_write, mem_be} !== {1'b1, 1'b0, 4'hF}) begin
            errors++;
            $display("FAIL br_mem got %b %b %h exp 1 0 f", mem_read, mem_write, mem_be);
        end
        @(negedge clk);
        checks++;
        if ({d_rvalid, d_err, d_rdata} !== {1'b1, 1'b0, 32'h0000CC00}) begin
            errors++;
            $display("FAIL br_rsp got %b %b %h exp 1 0 0000cc00", d_rvalid, d_err, d_rdata);
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        #1;
        checks++;
        if (d_gnt !== 1'b1) begin errors++; $display("FAIL oor_gnt got %b exp 1", d_gnt); end
        @(negedge clk);
        d_req = 1'b0;
        checks++;
        if ({mem_read, mem_write, d_rvalid, d_err, d_rdata, if_rvalid} !== {4'b0011, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL oor_rsp got %b %b %b %b %h %b exp 0 0 1 1 0 0",
                     mem_read, mem_write, d_rvalid, d_err, d_rdata, if_rvalid);
        end
        @(negedge clk);
        checks++;
        if ({mem_read, mem_write, d_rvalid} !== 3'b000) begin
            errors++;
            $display("FAIL oor_after got %b exp 000", {mem_read, mem_write, d_rvalid});
        end
    endtask

    task automatic test_timeout();
        stall = 1'b1;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        checks++;
        if (if_gnt !== 1'b1) begin errors++; $display("FAIL to_gnt got %b exp 1", if_gnt); end
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) begin
                if_req = 1'b0;
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h08;
                #1;
            end
            checks++;
            if ({mem_read, if_rvalid, d_gnt} !== 3'b100) begin
                errors++;
                $display("FAIL to_busy cycle %0d got %b exp 100", i, {mem_read, if_rvalid, d_gnt});
            end
        end
        @(negedge clk);
        checks++;
        if ({mem_read, if_rvalid, if_err, if_rdata, d_gnt} !== {3'b011, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL to_rsp got %b %b %b %h %b exp 0 1 1 0 1", mem_read, if_rvalid, if_err, if_rdata, d_gnt);
        end
        stall = 1'b0;
        @(negedge clk);
        d_req = 1'b0;
        checks++;
        if ({mem_read, mem_addr} !== {1'b1, 32'h08}) begin
            errors++;
            $display("FAIL to_next_mem got %b %h exp 1 00000008", mem_read, mem_addr);
        end
        @(negedge clk);
        checks++;
        if ({d_rvalid, d_err, d_rdata} !== {1'b1, 1'b0, 32'h0000CC00}) begin
            errors++;
            $display("FAIL to_next_rsp got %b %b %h exp 1 0 0000cc00", d_rvalid, d_err, d_rdata);
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_c [0:11];
        exp_c = '{4'b0100, 4'b0000, 4'b0101, 4'b0000, 4'b1001, 4'b0000,
                  4'b0110, 4'b0000, 4'b0101, 4'b0000, 4'b1001, 4'b0000};
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if_req = 1'b1; if_addr = 32'h40;
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h08;
            end
            #1;
            checks++;
            if ({if_gnt, d_gnt, if_rvalid, d_rvalid} !== exp_c[c]) begin
                errors++;
                $display("FAIL contention cycle %0d got %b exp %b", c, {if_gnt, d_gnt, if_rvalid, d_rvalid}, exp_c[c]);
            end
        end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        stall = 1'b1;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h12345678; d_be = 4'hF;
        #1;
        checks++;
        if (d_gnt !== 1'b1) begin errors++; $display("FAIL rst_gnt got %b exp 1", d_gnt); end
        @(negedge clk);
        d_req = 1'b0;
        checks++;
        if (mem_write !== 1'b1) begin errors++; $display("FAIL rst_busy got %b exp 1", mem_write); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== 140'h0) begin
            errors++;
            $display("FAIL rst_mid_outs got %h exp 0", all_outs);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({if_rvalid, d_rvalid, mem_write, mem_read} !== 4'b0000) begin
                errors++;
                $display("FAIL rst_quiet cycle %0d got %b exp 0000", i, {if_rvalid, d_rvalid, mem_write, mem_read});
            end
        end
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        checks++;
        if (if_gnt !== 1'b1) begin errors++; $display("FAIL rst_if_gnt got %b exp 1", if_gnt); end
        @(negedge clk);
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_rvalid, if_err, if_rdata} !== {1'b1, 1'b0, 32'hABCDEF00}) begin
            errors++;
            $display("FAIL rst_if_rsp got %b %b %h exp 1 0 abcdef00", if_rvalid, if_err, if_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        mem_clr = 1'b1;
        stall   = 1'b0;
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        d_be    = 4'h0;
        test_reset();
        test_if_read();
        test_d_byte_write();
        test_out_of_range();
        test_timeout();
        test_contention();
        test_reset_mid_busy();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
